// File: rtl/digi_ota_pkg.sv
// Shared types and defaults for the OTA/comparator calibration sequencer.
// Holds the FSM state encoding and the parameter defaults used by the top.
package digi_ota_pkg;

   localparam int TRIM_W_DEF     = 5;
   localparam int SETTLE_CYC_DEF = 4;
   localparam int VOTE_N_DEF     = 7;

   localparam logic [TRIM_W_DEF-1:0] TRIM_MID = TRIM_W_DEF'(1) << (TRIM_W_DEF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAL_SET,
      S_CAL_SETTLE,
      S_CAL_VOTE,
      S_CAL_DECIDE,
      S_DONE,
      S_RUN_SETTLE,
      S_RUN_VOTE
   } state_e;

   function automatic logic is_cal(input state_e s);
      return (s == S_CAL_SET) || (s == S_CAL_SETTLE) ||
             (s == S_CAL_VOTE) || (s == S_CAL_DECIDE);
   endfunction

endpackage

// File: rtl/ota_vote_acc.sv
// Majority-vote accumulator over VOTE_N comparator samples.
// win_done/maj are valid in the cycle of the last sample; the window restarts at once.
module ota_vote_acc #(
   parameter int VOTE_N = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic smp,
   input  logic bit_in,
   output logic win_done,
   output logic maj
);

   localparam int CW = $clog2(VOTE_N + 1);

   logic [CW-1:0] ones_q, ones_d;
   logic [CW-1:0] n_q, n_d;
   logic [CW-1:0] ones_inc;

   // Count ones and samples; wrap back to zero on the final sample of a window.
   always_comb begin
      ones_inc = ones_q + {{(CW-1){1'b0}}, bit_in};
      win_done = smp && (n_q == CW'(VOTE_N - 1));
      maj      = ones_inc > CW'(VOTE_N / 2);
      ones_d   = ones_q;
      n_d      = n_q;
      if (clr || win_done) begin
         ones_d = '0;
         n_d    = '0;
      end else if (smp) begin
         ones_d = ones_inc;
         n_d    = n_q + CW'(1);
      end
   end

   // Accumulator state.
   always_ff @(posedge clk) begin
      if (rst) begin
         ones_q <= '0;
         n_q    <= '0;
      end else begin
         ones_q <= ones_d;
         n_q    <= n_d;
      end
   end

endmodule

// File: rtl/digi_ota_cal_ctrl.sv
// Calibration / run sequencer for the digital OTA-comparator cell.
// Binary-search offset trim with majority-voted bits, then windowed RUN decisions.
module digi_ota_cal_ctrl
   import digi_ota_pkg::*;
#(
   parameter int TRIM_W     = TRIM_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int VOTE_N     = VOTE_N_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_cal,
   input  logic              run_en,
   input  logic              cmp_in,
   output logic              ota_en,
   output logic              az_short,
   output logic              out_oe,
   output logic [TRIM_W-1:0] trim,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              err,
   output logic              dec_out,
   output logic              dec_valid
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int BW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
   localparam logic [TRIM_W-1:0] MID = TRIM_W'(1) << (TRIM_W - 1);

   if (VOTE_N % 2 == 0) begin : g_vote_odd
      $error("VOTE_N must be odd");
   end
   if (SETTLE_CYC < 2) begin : g_settle_min
      $error("SETTLE_CYC must be >= 2 to cover the synchroniser");
   end

   state_e            state_q, state_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [SW-1:0]     set_q, set_d;
   logic              hi_q, hi_d;
   logic              sync1_q, cmp_s_q;
   logic              ota_en_q, ota_en_d;
   logic              az_short_q, az_short_d;
   logic              out_oe_q, out_oe_d;
   logic [TRIM_W-1:0] trim_q, trim_d;
   logic              cal_busy_q, cal_busy_d;
   logic              cal_done_q, cal_done_d;
   logic              err_q, err_d;
   logic              dec_out_q, dec_out_d;
   logic              dec_valid_q, dec_valid_d;

   logic              acc_clr, acc_smp, acc_done, acc_maj;
   logic [TRIM_W-1:0] onehot;
   logic              settle_end;

   ota_vote_acc #(.VOTE_N(VOTE_N)) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr),
      .smp      (acc_smp),
      .bit_in   (cmp_s_q),
      .win_done (acc_done),
      .maj      (acc_maj)
   );

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      set_d       = '0;
      hi_d        = hi_q;
      ota_en_d    = ota_en_q;
      az_short_d  = az_short_q;
      out_oe_d    = out_oe_q;
      trim_d      = trim_q;
      cal_done_d  = cal_done_q;
      err_d       = err_q;
      dec_out_d   = dec_out_q;
      dec_valid_d = 1'b0;
      acc_smp     = 1'b0;
      acc_clr     = !((state_q == S_CAL_VOTE) || (state_q == S_RUN_VOTE));
      onehot      = TRIM_W'(1) << bit_q;
      settle_end  = (set_q == SW'(SETTLE_CYC - 1));

      unique case (state_q)
         S_IDLE: begin
            if (start_cal) begin
               state_d    = S_CAL_SET;
               bit_d      = BW'(TRIM_W - 1);
               trim_d     = '0;
               cal_done_d = 1'b0;
               err_d      = 1'b0;
            end else if (run_en) begin
               state_d    = S_RUN_SETTLE;
               ota_en_d   = 1'b1;
               out_oe_d   = 1'b1;
               az_short_d = 1'b0;
            end
         end
         S_CAL_SET: begin
            trim_d     = trim_q | onehot;
            ota_en_d   = 1'b1;
            az_short_d = 1'b1;
            state_d    = S_CAL_SETTLE;
         end
         S_CAL_SETTLE: begin
            if (settle_end) state_d = S_CAL_VOTE;
            else set_d = set_q + SW'(1);
         end
         S_CAL_VOTE: begin
            acc_smp = 1'b1;
            if (acc_done) begin
               hi_d    = acc_maj;
               state_d = S_CAL_DECIDE;
            end
         end
         S_CAL_DECIDE: begin
            if (hi_q) trim_d = trim_q & ~onehot;
            if (bit_q == '0) begin
               state_d = S_DONE;
            end else begin
               bit_d   = bit_q - BW'(1);
               state_d = S_CAL_SET;
            end
         end
         S_DONE: begin
            cal_done_d = 1'b1;
            err_d      = (trim_q == '0) || (trim_q == '1);
            ota_en_d   = 1'b0;
            az_short_d = 1'b0;
            state_d    = S_IDLE;
         end
         S_RUN_SETTLE, S_RUN_VOTE: begin
            if (start_cal) begin
               state_d    = S_CAL_SET;
               bit_d      = BW'(TRIM_W - 1);
               trim_d     = '0;
               cal_done_d = 1'b0;
               err_d      = 1'b0;
               out_oe_d   = 1'b0;
            end else if (!run_en) begin
               state_d  = S_IDLE;
               ota_en_d = 1'b0;
               out_oe_d = 1'b0;
            end else if (state_q == S_RUN_SETTLE) begin
               if (settle_end) state_d = S_RUN_VOTE;
               else set_d = set_q + SW'(1);
            end else begin
               acc_smp = 1'b1;
               if (acc_done) begin
                  dec_out_d   = acc_maj;
                  dec_valid_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      cal_busy_d = is_cal(state_d);
   end

   // State, synchroniser and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_q       <= '0;
         set_q       <= '0;
         hi_q        <= 1'b0;
         sync1_q     <= 1'b0;
         cmp_s_q     <= 1'b0;
         ota_en_q    <= 1'b0;
         az_short_q  <= 1'b0;
         out_oe_q    <= 1'b0;
         trim_q      <= MID;
         cal_busy_q  <= 1'b0;
         cal_done_q  <= 1'b0;
         err_q       <= 1'b0;
         dec_out_q   <= 1'b0;
         dec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         set_q       <= set_d;
         hi_q        <= hi_d;
         sync1_q     <= cmp_in;
         cmp_s_q     <= sync1_q;
         ota_en_q    <= ota_en_d;
         az_short_q  <= az_short_d;
         out_oe_q    <= out_oe_d;
         trim_q      <= trim_d;
         cal_busy_q  <= cal_busy_d;
         cal_done_q  <= cal_done_d;
         err_q       <= err_d;
         dec_out_q   <= dec_out_d;
         dec_valid_q <= dec_valid_d;
      end
   end

   assign ota_en    = ota_en_q;
   assign az_short  = az_short_q;
   assign out_oe    = out_oe_q;
   assign trim      = trim_q;
   assign cal_busy  = cal_busy_q;
   assign cal_done  = cal_done_q;
   assign err       = err_q;
   assign dec_out   = dec_out_q;
   assign dec_valid = dec_valid_q;

endmodule
